// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared constants, FSM encoding and strobe-merge helper for the AXI-Lite write slave
package axi_lite_pkg;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_AW, WRITE, RESP} wr_state_t;
    function automatic logic [AXI_DATA_W-1:0] apply_strb(
        input logic [AXI_DATA_W-1:0] old_val,
        input logic [AXI_DATA_W-1:0] new_val,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] r;
        r = old_val;
        for (int i = 0; i < AXI_STRB_W; i++)
            r[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axi_lite_wr_regbank.sv
// axi_lite_wr_regbank: NUM_REGS x 32-bit register array with a byte-strobed write port
module axi_lite_wr_regbank
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                             ACLK,
    input  logic                             ARESETn,
    input  logic                             we,
    input  logic [7:0]                       idx,
    input  logic [AXI_DATA_W-1:0]            data,
    input  logic [AXI_STRB_W-1:0]            strb,
    output logic [AXI_DATA_W*NUM_REGS-1:0]   reg_q
);
    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            reg_q <= '0;
        else if (we)
            for (int k = 0; k < NUM_REGS; k++)
                if (idx == 8'(k))
                    reg_q[AXI_DATA_W*k +: AXI_DATA_W] <= apply_strb(reg_q[AXI_DATA_W*k +: AXI_DATA_W], data, strb);
    end
endmodule

// File: rtl/axi_lite_write_slave.sv
// axi_lite_write_slave: AXI4-Lite write responder, AW/W in any order, OKAY/SLVERR on B.
// Define AXI_WR_PROT_CHECK_EN to also reject unprivileged writes (AWPROT[0]=0) with SLVERR.
module axi_lite_write_slave
    import axi_lite_pkg::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [31:0]                    AWADDR,
    input  logic [2:0]                     AWPROT,
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [AXI_DATA_W-1:0]          WDATA,
    input  logic [AXI_STRB_W-1:0]          WSTRB,
    output logic                           BVALID,
    output logic [1:0]                     BRESP,
    input  logic                           BREADY,
    output logic [AXI_DATA_W*NUM_REGS-1:0] reg_q,
    output logic                           wr_pulse,
    output logic [7:0]                     wr_index,
    output logic [AXI_STRB_W-1:0]          wr_strb
);
    localparam logic [31:0] SPAN = 32'(4 * NUM_REGS);

    wr_state_t             state, state_n;
    logic [31:0]           addr_q, addr_n, off;
    logic [2:0]            prot_q, prot_n;
    logic [AXI_DATA_W-1:0] data_q, data_n;
    logic [AXI_STRB_W-1:0] strb_q, strb_n, wr_strb_n;
    logic                  awready_n, wready_n, bvalid_n, wr_pulse_n;
    logic [1:0]            bresp_n;
    logic [7:0]            idx, wr_index_n;
    logic                  aw_hs, w_hs, addr_err, prot_err, err, commit, wr_en;

    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign off      = addr_q - BASE_ADDR;
    assign idx      = off[9:2];
    assign addr_err = (addr_q < BASE_ADDR) || (off >= SPAN);
`ifdef AXI_WR_PROT_CHECK_EN
    assign prot_err = !prot_q[0];
`else
    logic unused_prot;
    assign prot_err    = 1'b0;
    assign unused_prot = ^prot_q;
`endif
    assign err    = addr_err || prot_err;
    assign commit = !err && (strb_q != '0);
    assign wr_en  = (state == WRITE) && commit;

    axi_lite_wr_regbank #(.NUM_REGS(NUM_REGS)) u_regbank (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .we      (wr_en),
        .idx     (idx),
        .data    (data_q),
        .strb    (strb_q),
        .reg_q   (reg_q)
    );

    always_comb begin
        state_n    = state;
        awready_n  = AWREADY;
        wready_n   = WREADY;
        bvalid_n   = BVALID;
        bresp_n    = BRESP;
        wr_pulse_n = 1'b0;
        wr_index_n = wr_index;
        wr_strb_n  = wr_strb;
        addr_n     = aw_hs ? AWADDR : addr_q;
        prot_n     = aw_hs ? AWPROT : prot_q;
        data_n     = w_hs ? WDATA : data_q;
        strb_n     = w_hs ? WSTRB : strb_q;
        case (state)
            // readies come up here on the first cycle after reset, then drop per handshake
            IDLE: begin
                awready_n = !aw_hs;
                wready_n  = !w_hs;
                state_n   = (aw_hs && w_hs) ? WRITE : aw_hs ? WAIT_W : w_hs ? WAIT_AW : IDLE;
            end
            WAIT_W: begin
                wready_n = !w_hs;
                state_n  = w_hs ? WRITE : WAIT_W;
            end
            WAIT_AW: begin
                awready_n = !aw_hs;
                state_n   = aw_hs ? WRITE : WAIT_AW;
            end
            WRITE: begin
                bvalid_n   = 1'b1;
                bresp_n    = err ? RESP_SLVERR : RESP_OKAY;
                wr_pulse_n = commit;
                wr_index_n = commit ? idx : wr_index;
                wr_strb_n  = commit ? strb_q : wr_strb;
                state_n    = RESP;
            end
            RESP: begin
                if (BREADY) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state    <= IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            wr_pulse <= 1'b0;
            wr_index <= '0;
            wr_strb  <= '0;
            addr_q   <= '0;
            prot_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            state    <= state_n;
            AWREADY  <= awready_n;
            WREADY   <= wready_n;
            BVALID   <= bvalid_n;
            BRESP    <= bresp_n;
            wr_pulse <= wr_pulse_n;
            wr_index <= wr_index_n;
            wr_strb  <= wr_strb_n;
            addr_q   <= addr_n;
            prot_q   <= prot_n;
            data_q   <= data_n;
            strb_q   <= strb_n;
        end
    end
endmodule

// File: tb/tb_axi_lite_write_slave.sv
// tb_axi_lite_write_slave: directed table, corner sequences and random writes against a register model
`timescale 1ns/1ps
module tb_axi_lite_write_slave;
    localparam int          NR   = 8;
    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef AXI_WR_PROT_CHECK_EN
    localparam bit PROT_CHK = 1'b1;
`else
    localparam bit PROT_CHK = 1'b0;
`endif

    logic          ACLK = 1'b0, ARESETn = 1'b0;
    logic          AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0;
    logic [31:0]   AWADDR = '0, WDATA = '0;
    logic [2:0]    AWPROT = '0;
    logic [3:0]    WSTRB = '0;
    logic          AWREADY, WREADY, BVALID, wr_pulse;
    logic [1:0]    BRESP;
    logic [32*NR-1:0] reg_q;
    logic [7:0]    wr_index;
    logic [3:0]    wr_strb;

    axi_lite_write_slave #(.NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
        .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_index(wr_index), .wr_strb(wr_strb)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, errors = 0;
    logic [31:0] model [NR];
    logic [7:0]  last_idx = '0;
    logic [3:0]  last_strb = '0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        int          gap;
        int          bwait;
        logic [1:0]  resp;
        logic        pulse;
    } vec_t;
    vec_t tbl[$];

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int k = 0; k < NR; k++)
            chk($sformatf("%s_reg%0d", tag, k), reg_q[32*k +: 32], model[k]);
    endtask

    // Reference: plain address arithmetic on an array of words
    task automatic model_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp, output logic pulse);
        logic [31:0] off;
        bit bad;
        int w;
        off   = addr - BASE;
        bad   = (addr < BASE) || (off >= 32'(4 * NR)) || (PROT_CHK && !prot[0]);
        resp  = bad ? 2'b10 : 2'b00;
        pulse = !bad && (strb != 0);
        if (pulse) begin
            w = int'(off / 4);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[w][8*b +: 8] = data[8*b +: 8];
            last_idx  = 8'(w);
            last_strb = strb;
        end
    endtask

    // mode 0: AW+W together, 1: AW first then W after gap, 2: W first then AW after gap
    task automatic write_txn(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input int gap, input int bwait,
                             input logic [1:0] exp_resp, input logic exp_pulse);
        int n;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin
            tick;
            n++;
        end
        chk("idle_ready", 32'({AWREADY, WREADY}), 32'h3);
        AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
        if (mode == 0) begin
            AWVALID = 1'b1; WVALID = 1'b1;
            tick;
            AWVALID = 1'b0; WVALID = 1'b0;
        end else if (mode == 1) begin
            AWVALID = 1'b1;
            tick;
            chk("aw_only_ready", 32'({AWREADY, WREADY}), 32'h1);
            AWADDR = ~addr;
            repeat (gap) begin
                tick;
                chk("wait_w_awready", 32'(AWREADY), 32'h0);
                chk("wait_w_bvalid", 32'(BVALID), 32'h0);
            end
            AWVALID = 1'b0; AWADDR = addr; WVALID = 1'b1;
            tick;
            WVALID = 1'b0;
        end else begin
            WVALID = 1'b1;
            tick;
            chk("w_only_ready", 32'({AWREADY, WREADY}), 32'h2);
            WDATA = ~data;
            repeat (gap) begin
                tick;
                chk("wait_aw_wready", 32'(WREADY), 32'h0);
                chk("wait_aw_bvalid", 32'(BVALID), 32'h0);
            end
            WVALID = 1'b0; WDATA = data; AWVALID = 1'b1;
            tick;
            AWVALID = 1'b0;
        end
        chk("hs_ready_low", 32'({AWREADY, WREADY}), 32'h0);
        chk("hs_bvalid", 32'(BVALID), 32'h0);
        chk("hs_pulse", 32'(wr_pulse), 32'h0);
        tick;
        chk("bvalid", 32'(BVALID), 32'h1);
        chk("bresp", 32'(BRESP), 32'(exp_resp));
        chk("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
        chk("wr_index", 32'(wr_index), 32'(last_idx));
        chk("wr_strb", 32'(wr_strb), 32'(last_strb));
        chk_regs("commit");
        repeat (bwait) begin
            tick;
            chk("hold_bvalid", 32'(BVALID), 32'h1);
            chk("hold_bresp", 32'(BRESP), 32'(exp_resp));
            chk("hold_ready", 32'({AWREADY, WREADY}), 32'h0);
            chk("hold_pulse", 32'(wr_pulse), 32'h0);
        end
        BREADY = 1'b1;
        tick;
        BREADY = 1'b0;
        chk("b_done_bvalid", 32'(BVALID), 32'h0);
        chk("b_done_ready", 32'({AWREADY, WREADY}), 32'h3);
        chk("b_done_pulse", 32'(wr_pulse), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic p;
        logic [31:0] a;
        for (int k = 0; k < NR; k++) model[k] = '0;
        tbl.push_back('{BASE + 32'd4,  3'b001, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b1});
        tbl.push_back('{BASE + 32'd8,  3'b001, 32'hAABBCCDD, 4'hF, 0, 0, 0, 2'b00, 1'b1});
        tbl.push_back('{BASE + 32'd8,  3'b001, 32'h11223344, 4'h5, 1, 3, 0, 2'b00, 1'b1});
        tbl.push_back('{BASE + 32'd12, 3'b001, 32'h01020304, 4'hF, 2, 2, 5, 2'b00, 1'b1});
        tbl.push_back('{BASE + 32'd32, 3'b001, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b10, 1'b0});
        tbl.push_back('{BASE + 32'd32, 3'b001, 32'hFFFFFFFF, 4'hF, 1, 1, 0, 2'b10, 1'b0});
        tbl.push_back('{BASE - 32'd4,  3'b001, 32'hFFFFFFFF, 4'hF, 2, 1, 1, 2'b10, 1'b0});
        tbl.push_back('{BASE + 32'd28, 3'b001, 32'hCAFEF00D, 4'h8, 0, 0, 0, 2'b00, 1'b1});
        tbl.push_back('{BASE + 32'h13, 3'b001, 32'h55667788, 4'h3, 0, 0, 0, 2'b00, 1'b1});
        tbl.push_back('{BASE + 32'd20, 3'b001, 32'h12345678, 4'h0, 0, 0, 0, 2'b00, 1'b0});
        tbl.push_back('{BASE,          3'b000, 32'h0BADF00D, 4'hF, 0, 0, 0, PROT_CHK ? 2'b10 : 2'b00, !PROT_CHK});
        tbl.push_back('{BASE,          3'b001, 32'h600DF00D, 4'hF, 0, 0, 0, 2'b00, 1'b1});

        repeat (3) tick;
        chk("rst_awready", 32'(AWREADY), 32'h0);
        chk("rst_wready", 32'(WREADY), 32'h0);
        chk("rst_bvalid", 32'(BVALID), 32'h0);
        chk("rst_bresp", 32'(BRESP), 32'h0);
        chk("rst_pulse", 32'(wr_pulse), 32'h0);
        chk("rst_index", 32'(wr_index), 32'h0);
        chk("rst_strb", 32'(wr_strb), 32'h0);
        chk_regs("rst");
        ARESETn = 1'b1;
        tick;
        chk("release_ready", 32'({AWREADY, WREADY}), 32'h3);

        foreach (tbl[i]) begin
            model_write(tbl[i].addr, tbl[i].prot, tbl[i].data, tbl[i].strb, r, p);
            write_txn(tbl[i].addr, tbl[i].prot, tbl[i].data, tbl[i].strb,
                      tbl[i].mode, tbl[i].gap, tbl[i].bwait, tbl[i].resp, tbl[i].pulse);
        end
        chk("t_reg1", reg_q[32*1 +: 32], 32'hDEADBEEF);
        chk("t_reg2", reg_q[32*2 +: 32], 32'hAA22CC44);
        chk("t_reg3", reg_q[32*3 +: 32], 32'h01020304);
        chk("t_reg4", reg_q[32*4 +: 32], 32'h00007788);
        chk("t_reg7", reg_q[32*7 +: 32], 32'hCA000000);
        chk("t_reg0", reg_q[32*0 +: 32], 32'h600DF00D);

        for (int t = 0; t < 50; t++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'($urandom_range(1, 16));
                1:       a = BASE + 32'(4 * NR) + 32'($urandom_range(0, 200));
                default: a = BASE + 32'($urandom_range(0, 4 * NR - 1));
            endcase
            AWPROT = 3'($urandom_range(0, 7));
            WSTRB  = 4'($urandom_range(0, 15));
            WDATA  = $urandom;
            model_write(a, AWPROT, WDATA, WSTRB, r, p);
            write_txn(a, AWPROT, WDATA, WSTRB, $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 3), r, p);
        end

        // reset while a response is pending drops it without a B handshake
        AWADDR = BASE + 32'd4; AWPROT = 3'b001; WDATA = 32'h13579BDF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        tick;
        AWVALID = 1'b0; WVALID = 1'b0;
        tick;
        chk("pre_rst_bvalid", 32'(BVALID), 32'h1);
        ARESETn = 1'b0;
        tick;
        ARESETn = 1'b1;
        for (int k = 0; k < NR; k++) model[k] = '0;
        last_idx = '0; last_strb = '0;
        chk("mid_rst_bvalid", 32'(BVALID), 32'h0);
        chk("mid_rst_ready", 32'({AWREADY, WREADY}), 32'h0);
        chk("mid_rst_index", 32'(wr_index), 32'h0);
        chk_regs("mid_rst");
        BREADY = 1'b1;
        tick;
        chk("post_rst_ready", 32'({AWREADY, WREADY}), 32'h3);
        chk("post_rst_bvalid", 32'(BVALID), 32'h0);
        tick;
        chk("post_rst_no_b", 32'(BVALID), 32'h0);
        BREADY = 1'b0;
        model_write(BASE + 32'd24, 3'b001, 32'h89ABCDEF, 4'hE, r, p);
        write_txn(BASE + 32'd24, 3'b001, 32'h89ABCDEF, 4'hE, 0, 0, 0, 2'b00, 1'b1);
        chk("final_reg6", reg_q[32*6 +: 32], 32'h89ABCD00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
